// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: hands out ROB entry IDs at dispatch, retires them at commit,
// and stalls ID while the ROB is full or recovering from a flush.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_NORMAL  | allocation allowed whenever ROB has room and downstream is free
// ST_RECOVER | post-flush hold; allocation blocked, ID stalled
module rob_alloc_ctrl #(
    parameter int ROB_ADDR_WIDTH = 4,
    parameter int FLUSH_HOLD     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      dispatch_req,
    input  logic                      stall_next_stage,
    input  logic                      commit_en,
    output logic                      alloc_en,
    output logic [ROB_ADDR_WIDTH-1:0] alloc_id,
    output logic [ROB_ADDR_WIDTH-1:0] head_id,
    output logic                      stall_current_stage,
    output logic                      rob_full,
    output logic                      rob_empty,
    output logic [ROB_ADDR_WIDTH:0]   free_count
);

    localparam int AW     = ROB_ADDR_WIDTH;
    localparam int DEPTH  = 1 << AW;
    localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

    localparam logic [AW:0]       DEPTH_V   = (AW+1)'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((FLUSH_HOLD > 0) ? FLUSH_HOLD - 1 : 0);

    localparam logic ST_NORMAL  = 1'b0;
    localparam logic ST_RECOVER = 1'b1;

    logic [AW-1:0]     tail_q, tail_d;
    logic [AW-1:0]     head_q, head_d;
    logic [AW:0]       count_q, count_d;
    logic              state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              commit_ok;

    assign rob_full   = (count_q == DEPTH_V);
    assign rob_empty  = (count_q == '0);
    assign free_count = DEPTH_V - count_q;
    assign alloc_id   = tail_q;
    assign head_id    = head_q;

    // A commit on a full ROB frees the slot only at the edge, so no same-cycle bypass.
    assign alloc_en = dispatch_req & ~rob_full & ~stall_next_stage & ~flush
                      & (state_q == ST_NORMAL);
    assign commit_ok = commit_en & ~rob_empty & ~flush;

    assign stall_current_stage = (state_q == ST_RECOVER) | (dispatch_req & rob_full);

    always_comb begin
        tail_d  = tail_q;
        head_d  = head_q;
        count_d = count_q;
        state_d = state_q;
        hold_d  = hold_q;

        if (flush) begin
            tail_d  = '0;
            head_d  = '0;
            count_d = '0;
            if (FLUSH_HOLD > 0) begin
                state_d = ST_RECOVER;
                hold_d  = HOLD_INIT;
            end else begin
                state_d = ST_NORMAL;
                hold_d  = '0;
            end
        end else begin
            tail_d = tail_q + AW'(alloc_en);
            head_d = head_q + AW'(commit_ok);
            case ({alloc_en, commit_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (state_q == ST_RECOVER) begin
                if (hold_q == '0) begin
                    state_d = ST_NORMAL;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tail_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
            state_q <= ST_NORMAL;
            hold_q  <= '0;
        end else begin
            tail_q  <= tail_d;
            head_q  <= head_d;
            count_q <= count_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
- Allocation controller in front of the ID→ROB pipeline register.
- Tracks reorder-buffer head/tail pointers and occupancy.
- Hands one ROB entry ID to each instruction leaving ID, and retires entries at commit.
- Generates the current-stage stall for the ID/ROB register when the ROB is full or recovering after a flush.

Parameters:
- ROB_ADDR_WIDTH, 4, log2 of ROB depth (depth = 2^ROB_ADDR_WIDTH = 16).
- FLUSH_HOLD, 2, cycles the stall is held after a flush; 0 disables the hold.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- flush  in  1  pipeline flush; discards all ROB contents.
- dispatch_req  in  1  ID holds a valid instruction needing a ROB entry.
- stall_next_stage  in  1  downstream stall; blocks allocation.
- commit_en  in  1  ROB head entry retires this cycle.
- alloc_en  out  1  an entry is allocated this cycle.
- alloc_id  out  ROB_ADDR_WIDTH  entry ID for the dispatching instruction (tail pointer).
- head_id  out  ROB_ADDR_WIDTH  oldest entry (head pointer).
- stall_current_stage  out  1  stall request to ID and the ID/ROB register.
- rob_full  out  1  occupancy == depth.
- rob_empty  out  1  occupancy == 0.
- free_count  out  ROB_ADDR_WIDTH+1  depth − occupancy.

Behaviour:
- Registered state:
  - tail, head: ROB_ADDR_WIDTH each.
  - count: ROB_ADDR_WIDTH+1, range 0..depth.
  - state: NORMAL or RECOVER.
  - hold_cnt: sized for FLUSH_HOLD.
- Reset (rst==0 at posedge): tail=0, head=0, count=0, state=NORMAL, hold_cnt=0. Reset overrides flush and everything else.
- Outputs after reset: alloc_id=0, head_id=0, rob_empty=1, rob_full=0, free_count=depth; alloc_en=0 and stall_current_stage=0 unless dispatch_req.
- Combinational outputs from current registers:
  - alloc_en = dispatch_req & ~rob_full & ~stall_next_stage & ~flush & (state==NORMAL).
  - commit_ok = commit_en & ~rob_empty & ~flush. commit_en when empty is ignored.
  - stall_current_stage = (state==RECOVER) | (dispatch_req & rob_full).
  - alloc_id = tail; head_id = head.
- Update at posedge, when not in reset and not flushing:
  - tail += alloc_en; head += commit_ok. Both wrap modulo depth, no saturation.
  - count += alloc_en − commit_ok. Simultaneous alloc and commit leaves count unchanged.
- No full bypass: when rob_full=1 and commit_en=1 in the same cycle, there is no allocation that cycle. Allocation succeeds next cycle.
- Zero-latency allocation: the ID consumed in cycle N is alloc_id in cycle N. tail advances at the N→N+1 edge.
- Flush at posedge:
  - tail=head=0, count=0. Any concurrent alloc/commit is discarded.
  - FLUSH_HOLD>0: state=RECOVER, hold_cnt=FLUSH_HOLD−1.
  - FLUSH_HOLD==0: state=NORMAL.
- RECOVER state:
  - stall_current_stage=1, alloc_en=0.
  - hold_cnt==0 → NORMAL at next edge; otherwise hold_cnt−−.
  - A flush while in RECOVER reloads hold_cnt.
- Stall interaction: stall_next_stage=1 suppresses allocation but does not itself raise stall_current_stage. The ID/ROB register already receives stall_next_stage directly.
- Invariants: count never exceeds depth and never underflows. free_count == depth − count at all times.

Test Plan:
- Reset then 16 consecutive dispatch_req cycles, no commit → alloc_id 0..15 in order, rob_full=1 after the 16th edge. The 17th request gives stall_current_stage=1, alloc_en=0, free_count=0.
- Full ROB, dispatch_req=1 and commit_en=1 same cycle → no alloc that cycle, head_id 0→1, count 16→15. Next cycle alloc_en=1 with alloc_id=0 (wrap).
- count=5, dispatch_req=1 and commit_en=1 for 10 cycles → count stays 5. tail and head each advance by 10 modulo 16.
- Empty ROB, commit_en=1 → head_id stays 0, count stays 0, rob_empty=1.
- count=7, flush pulse with FLUSH_HOLD=2 → next cycle tail=head=0, rob_empty=1, stall_current_stage=1 for exactly 2 cycles. Allocation resumes in the 3rd cycle with alloc_id=0. A second flush during the hold restarts the 2-cycle hold.
- dispatch_req=1 with stall_next_stage=1 → alloc_en=0, stall_current_stage=0, tail unchanged. rst=0 mid-sequence with flush=1 → all registers at reset values the next cycle, state=NORMAL (no hold).
